cacheline_adapter: RTL

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 102 ++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// Bridges cache line requests (one 256-bit line) to 4-beat memory bursts.
// Fill data is assembled beat by beat; write-back data is streamed beat by beat.
module cacheline_adapter #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int n_beats = s_line / s_burst;
  localparam int cnt_w   = $clog2(n_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e              state_q, state_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [s_line-1:0]   wline_q, wline_d;
  logic [s_line-1:0]   line_q, line_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write-back wins so a dirty victim leaves before the refill arrives.
        if (write_i) begin
          addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
          wline_d = line_i;
          cnt_d   = '0;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[s_burst*int'(cnt_q) +: s_burst] = burst_i;
          cnt_d = cnt_q + cnt_w'(1);
          if (cnt_q == last_beat) state_d = DONE;
        end
      end
      WR: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + cnt_w'(1);
          if (cnt_q == last_beat) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign burst_o   = wline_q[s_burst*int'(cnt_q) +: s_burst];
  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule
